// File: rtl/debug_mem_bridge_if.sv
// Byte-stream and memory-port signal bundle for debug_mem_bridge.
// The slave modport is the bridge side; the master modport is the host/RAM side.
interface debug_mem_bridge_if;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [BE_W-1:0]   mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  rx_data, rx_valid, tx_ready, mem_rdata,
        output rx_ready, tx_data, tx_valid, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output rx_data, rx_valid, tx_ready, mem_rdata,
        input  rx_ready, tx_data, tx_valid, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/debug_mem_bridge.sv
// Debug host byte-stream to data-RAM port-b bridge (single word read/write commands).
// Optional inter-byte idle timeout enabled by defining DEBUG_MEM_TIMEOUT_EN.
module debug_mem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                rst,
    debug_mem_bridge_if.slave   bus,
    output logic                busy
);
    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, MEM_WR, MEM_RD, CAPTURE, SEND
    } state_t;

    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_READ  = 4'h2;
    localparam logic [7:0] RSP_ACK  = 8'hAA;
    localparam logic [7:0] RSP_ERR  = 8'hEE;

    // The idle counter is 16 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [1:0]  tx_left;
    logic        is_read;
    logic [3:0]  be;
    logic [23:0] addr_sr;
    logic [23:0] data_sr;
    logic [23:0] rd_sr;
    logic        rx_fire;
    logic        tx_fire;

    assign rx_fire = bus.rx_valid && bus.rx_ready;
    assign tx_fire = bus.tx_valid && bus.tx_ready;

`ifdef DEBUG_MEM_TIMEOUT_EN
    logic [15:0] idle_cnt;
    logic        timeout_hit;
    assign timeout_hit = (idle_cnt == 16'(TIMEOUT_CYCLES - 1));
`endif

    // Control FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            byte_cnt      <= 2'd0;
            tx_left       <= 2'd0;
            is_read       <= 1'b0;
            be            <= 4'h0;
            addr_sr       <= 24'h0;
            data_sr       <= 24'h0;
            rd_sr         <= 24'h0;
            busy          <= 1'b0;
            bus.rx_ready  <= 1'b1;
            bus.tx_valid  <= 1'b0;
            bus.tx_data   <= 8'h00;
            bus.mem_addr  <= 30'h0;
            bus.mem_we    <= 4'h0;
            bus.mem_wdata <= 32'h0;
`ifdef DEBUG_MEM_TIMEOUT_EN
            idle_cnt      <= 16'h0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (rx_fire) begin
                        byte_cnt <= 2'd0;
                        busy     <= 1'b1;
                        if (bus.rx_data[7:4] == OP_WRITE || bus.rx_data[7:4] == OP_READ) begin
                            state   <= GET_ADDR;
                            is_read <= (bus.rx_data[7:4] == OP_READ);
                            be      <= bus.rx_data[3:0];
                        end else begin
                            state        <= SEND;
                            tx_left      <= 2'd0;
                            bus.tx_valid <= 1'b1;
                            bus.tx_data  <= RSP_ERR;
                            bus.rx_ready <= 1'b0;
                        end
                    end
                end
                GET_ADDR: begin
                    if (rx_fire) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        addr_sr  <= {addr_sr[15:0], bus.rx_data};
                        if (byte_cnt == 2'd3) begin
                            // Byte address bits [1:0] are dropped; the RAM is word addressed.
                            bus.mem_addr <= {addr_sr, bus.rx_data[7:2]};
                            if (is_read) begin
                                state        <= MEM_RD;
                                bus.rx_ready <= 1'b0;
                            end else begin
                                state <= GET_DATA;
                            end
                        end
                    end
`ifdef DEBUG_MEM_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
`endif
                end
                GET_DATA: begin
                    if (rx_fire) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        data_sr  <= {data_sr[15:0], bus.rx_data};
                        if (byte_cnt == 2'd3) begin
                            state         <= MEM_WR;
                            bus.mem_we    <= be;
                            bus.mem_wdata <= {data_sr, bus.rx_data};
                            bus.rx_ready  <= 1'b0;
                        end
                    end
`ifdef DEBUG_MEM_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
`endif
                end
                MEM_WR: begin
                    state        <= SEND;
                    bus.mem_we   <= 4'h0;
                    tx_left      <= 2'd0;
                    bus.tx_valid <= 1'b1;
                    bus.tx_data  <= RSP_ACK;
                end
                MEM_RD: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    state        <= SEND;
                    tx_left      <= 2'd3;
                    bus.tx_valid <= 1'b1;
                    bus.tx_data  <= bus.mem_rdata[31:24];
                    rd_sr        <= bus.mem_rdata[23:0];
                end
                SEND: begin
                    if (tx_fire) begin
                        if (tx_left == 2'd0) begin
                            state        <= IDLE;
                            bus.tx_valid <= 1'b0;
                            bus.rx_ready <= 1'b1;
                            busy         <= 1'b0;
                        end else begin
                            tx_left     <= tx_left - 2'd1;
                            bus.tx_data <= rd_sr[23:16];
                            rd_sr       <= {rd_sr[15:0], 8'h00};
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.mem_we   <= 4'h0;
                    bus.tx_valid <= 1'b0;
                    bus.rx_ready <= 1'b1;
                    busy         <= 1'b0;
                end
            endcase
`ifdef DEBUG_MEM_TIMEOUT_EN
            // Idle timer restarts on every accepted byte and only runs while collecting a frame.
            if (rx_fire || !(state == GET_ADDR || state == GET_DATA)) begin
                idle_cnt <= 16'h0;
            end else begin
                idle_cnt <= idle_cnt + 16'd1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_debug_mem_bridge.sv
// Directed self-checking bench for debug_mem_bridge with a synchronous-read RAM model.
module tb_debug_mem_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    int   we_cycles = 0;
    logic [29:0] last_we_addr;
    logic [3:0]  last_we;
    logic [31:0] last_wdata;
    logic [31:0] mem [16];

    debug_mem_bridge_if bus();

    debug_mem_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Port-b RAM: one-cycle synchronous read.
    always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr[3:0]];

    // Record every cycle with a non-zero write enable.
    always @(posedge clk) begin
        if (bus.mem_we != 4'h0) begin
            we_cycles    <= we_cycles + 1;
            last_we_addr <= bus.mem_addr;
            last_we      <= bus.mem_we;
            last_wdata   <= bus.mem_wdata;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout: rx_ready %b, required 1 for byte %h", bus.rx_ready, b);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b);
        int n = 0;
        bus.tx_ready = 1'b1;
        while (bus.tx_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL recv_timeout: tx_valid %b, required 1", bus.tx_valid);
        end
        b = bus.tx_data;
        @(negedge clk);
        bus.tx_ready = 1'b0;
    endtask

    task automatic recv_word(input string name, input logic [31:0] exp);
        logic [7:0] b;
        logic [31:0] w = 32'h0;
        for (int i = 0; i < 4; i++) begin
            recv_byte(b);
            w = {w[23:0], b};
        end
        checks++;
        if (w !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, w, exp);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.rx_ready !== 1'b1 || bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 ||
            bus.mem_addr !== 30'h0 || bus.mem_we !== 4'h0 || bus.mem_wdata !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: rdy %b tv %b td %h addr %h we %h wd %h busy %b, required 1 0 00 0 0 0 0",
                     bus.rx_ready, bus.tx_valid, bus.tx_data, bus.mem_addr, bus.mem_we, bus.mem_wdata, busy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_full;
        logic [7:0] f [9] = '{8'h1F, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        logic [7:0] r;
        int w0 = we_cycles;
        for (int i = 0; i < 9; i++) send_byte(f[i]);
        checks++;
        if (bus.mem_we !== 4'hF || bus.mem_addr !== 30'h4 || bus.mem_wdata !== 32'hDEADBEEF || bus.tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_cycle: we %h addr %h wd %h tv %b, required f 4 deadbeef 0",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.tx_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.mem_we !== 4'h0 || bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hAA || busy !== 1'b1) begin
            errors++;
            $display("FAIL wr_after: we %h tv %b td %h busy %b, required 0 1 aa 1",
                     bus.mem_we, bus.tx_valid, bus.tx_data, busy);
        end
        recv_byte(r);
        checks++;
        if (r !== 8'hAA || we_cycles - w0 != 1) begin
            errors++;
            $display("FAIL wr_resp: resp %h we_cycles %0d, required aa 1", r, we_cycles - w0);
        end
        checks++;
        if (busy !== 1'b0 || bus.rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_idle: busy %b rdy %b, required 0 1", busy, bus.rx_ready);
        end
    endtask

    task automatic test_read;
        logic [7:0] f [5] = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h12};
        for (int i = 0; i < 5; i++) send_byte(f[i]);
        // Now just past edge N (last address byte accepted).
        checks++;
        if (bus.mem_addr !== 30'h4 || bus.tx_valid !== 1'b0 || bus.rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL rd_addr: addr %h tv %b rdy %b, required 4 0 0", bus.mem_addr, bus.tx_valid, bus.rx_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_lat_n1: tv %b, required 0", bus.tx_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h12) begin
            errors++;
            $display("FAIL rd_lat_n2: tv %b td %h, required 1 12", bus.tx_valid, bus.tx_data);
        end
        recv_word("rd_data", 32'h12345678);
    endtask

    task automatic test_partial_we;
        logic [7:0] f [9] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h08, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        logic [7:0] g [9] = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] r;
        int w0 = we_cycles;
        for (int i = 0; i < 9; i++) send_byte(f[i]);
        checks++;
        if (bus.mem_we !== 4'b0011 || bus.mem_addr !== 30'h2 || bus.mem_wdata !== 32'hAABBCCDD) begin
            errors++;
            $display("FAIL we3_cycle: we %h addr %h wd %h, required 3 2 aabbccdd", bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        recv_byte(r);
        checks++;
        if (r !== 8'hAA || we_cycles - w0 != 1 || last_we !== 4'b0011) begin
            errors++;
            $display("FAIL we3_resp: resp %h cycles %0d we %h, required aa 1 3", r, we_cycles - w0, last_we);
        end
        w0 = we_cycles;
        for (int i = 0; i < 9; i++) send_byte(g[i]);
        checks++;
        if (bus.mem_we !== 4'h0 || bus.mem_addr !== 30'h3 || bus.mem_wdata !== 32'h11223344) begin
            errors++;
            $display("FAIL we0_cycle: we %h addr %h wd %h, required 0 3 11223344", bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        recv_byte(r);
        checks++;
        if (r !== 8'hAA || we_cycles != w0) begin
            errors++;
            $display("FAIL we0_resp: resp %h we_cycles %0d, required aa 0", r, we_cycles - w0);
        end
    endtask

    task automatic test_invalid_backpressure;
        logic [7:0] r;
        logic [7:0] f [4] = '{8'h00, 8'h00, 8'h00, 8'h10};
        int w0 = we_cycles;
        send_byte(8'h55);
        bus.rx_data  = 8'h20;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hEE || bus.rx_ready !== 1'b0 || bus.mem_we !== 4'h0) begin
                errors++;
                $display("FAIL inv_hold%0d: tv %b td %h rdy %b we %h, required 1 ee 0 0",
                         i, bus.tx_valid, bus.tx_data, bus.rx_ready, bus.mem_we);
            end
            @(negedge clk);
        end
        recv_byte(r);
        checks++;
        if (r !== 8'hEE || we_cycles != w0) begin
            errors++;
            $display("FAIL inv_resp: resp %h we_cycles %0d, required ee 0", r, we_cycles - w0);
        end
        // The read command byte held during the stall must still be taken.
        send_byte(8'h20);
        for (int i = 0; i < 4; i++) send_byte(f[i]);
        recv_word("bp_read", 32'h12345678);
    endtask

    task automatic test_reset_midframe;
        logic [7:0] f [5] = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h10};
        int w0 = we_cycles;
        send_byte(8'h1F);
        send_byte(8'h00);
        send_byte(8'h00);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.rx_ready !== 1'b1 || bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 ||
            bus.mem_addr !== 30'h0 || bus.mem_we !== 4'h0 || bus.mem_wdata !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: rdy %b tv %b td %h addr %h we %h wd %h busy %b, required 1 0 00 0 0 0 0",
                     bus.rx_ready, bus.tx_valid, bus.tx_data, bus.mem_addr, bus.mem_we, bus.mem_wdata, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) send_byte(f[i]);
        recv_word("post_reset_read", 32'h12345678);
        checks++;
        if (we_cycles != w0) begin
            errors++;
            $display("FAIL mid_reset_we: we_cycles %0d, required 0", we_cycles - w0);
        end
    endtask

    task automatic test_timeout;
        int w0 = we_cycles;
        int tv_seen = 0;
        send_byte(8'h20);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.tx_valid === 1'b1) tv_seen++;
        end
`ifdef DEBUG_MEM_TIMEOUT_EN
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL to_early: busy %b after 15 idle cycles, required 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.rx_ready !== 1'b1 || tv_seen != 0 || bus.tx_valid !== 1'b0 || we_cycles != w0) begin
            errors++;
            $display("FAIL to_expire: busy %b rdy %b tx_seen %0d we_cycles %0d, required 0 1 0 0",
                     busy, bus.rx_ready, tv_seen, we_cycles - w0);
        end
        begin
            logic [7:0] f [5] = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h10};
            for (int i = 0; i < 5; i++) send_byte(f[i]);
            recv_word("to_recover_read", 32'h12345678);
        end
`else
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.tx_valid === 1'b1) tv_seen++;
        end
        checks++;
        if (busy !== 1'b1 || bus.rx_ready !== 1'b1 || tv_seen != 0 || we_cycles != w0) begin
            errors++;
            $display("FAIL no_timeout: busy %b rdy %b tx_seen %0d, required 1 1 0", busy, bus.rx_ready, tv_seen);
        end
        begin
            logic [7:0] f [4] = '{8'h00, 8'h00, 8'h00, 8'h10};
            for (int i = 0; i < 4; i++) send_byte(f[i]);
            recv_word("stall_read", 32'h12345678);
        end
`endif
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[4] = 32'h12345678;
        test_reset();
        test_write_full();
        test_read();
        test_partial_we();
        test_invalid_backpressure();
        test_reset_midframe();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/debug_mem_bridge.md
DEBUG_MEM_BRIDGE -- requirements
Module: debug_mem_bridge

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 65535, meaning inter-byte idle limit in clk cycles (used only when DEBUG_MEM_TIMEOUT_EN is defined).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 rx_data  input  8  command byte stream from debug host.
REQ-005 rx_valid  input  1  rx_data valid.
REQ-006 rx_ready  output  1  bridge accepts byte; transfer when rx_valid && rx_ready.
REQ-007 tx_data  output  8  response byte.
REQ-008 tx_valid  output  1  tx_data valid.
REQ-009 tx_ready  input  1  host accepts byte; transfer when tx_valid && tx_ready.
REQ-010 mem_addr  output  30  word address [31:2] to data RAM port b.
REQ-011 mem_we  output  4  per-byte write enable to data RAM port b.
REQ-012 mem_wdata  output  32  write data to data RAM port b.
REQ-013 mem_rdata  input  32  read data from data RAM port b.
REQ-014 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-015 Command frame SHALL be: 1 command byte, 4 address bytes MSB first, then 4 data bytes MSB first for writes only.
REQ-016 Command byte SHALL decode as: [7:4]=0x1 write with byte enables [3:0]; [7:4]=0x2 read ([3:0] ignored); any other opcode invalid.
REQ-017 FSM states SHALL be IDLE, GET_ADDR, GET_DATA, MEM_WR, MEM_RD, CAPTURE, SEND.
REQ-018 IDLE: valid write/read command -> GET_ADDR; invalid command -> SEND with single byte 0xEE.
REQ-019 GET_ADDR: a 2-bit byte counter SHALL count accepted bytes; after 4th byte -> GET_DATA (write) or MEM_RD (read).
REQ-020 GET_DATA: after 4th byte -> MEM_WR.
REQ-021 rx_ready SHALL be 1 only in IDLE, GET_ADDR, GET_DATA.
REQ-022 mem_addr SHALL equal assembled address bits [31:2]; address bits [1:0] discarded; value held until next command updates it.
REQ-023 MEM_WR SHALL last exactly 1 cycle with mem_we = command [3:0] and mem_wdata = assembled data; then SEND with single byte 0xAA.
REQ-024 Write with byte enables 4'b0000 SHALL still pass through MEM_WR (mem_we stays 0) and return 0xAA.
REQ-025 mem_we SHALL be 4'b0000 in every state except MEM_WR.
REQ-026 MEM_RD: 1 cycle presenting mem_addr; CAPTURE: latch mem_rdata into a 32-bit shift register; then SEND with 4 bytes MSB first.
REQ-027 SEND: tx_valid high, tx_data stable until accepted; next byte presented the cycle after acceptance; after last byte -> IDLE.
REQ-028 Read latency SHALL be: last address byte accepted at edge N -> tx_valid high after edge N+2.
REQ-029 rx bytes arriving in MEM_WR, MEM_RD, CAPTURE, SEND SHALL be back-pressured (not dropped).

Reset
REQ-030 On rst: state IDLE, counters 0, rx_ready 1, tx_valid 0, tx_data 8'h00, mem_addr 0, mem_we 0, mem_wdata 0, busy 0.
REQ-031 rst asserted mid-frame or mid-SEND SHALL discard the partial command/response without any memory write.

Configuration
REQ-032 With DEBUG_MEM_TIMEOUT_EN defined: a 16-bit counter SHALL reset on every accepted byte and increment in GET_ADDR/GET_DATA; reaching TIMEOUT_CYCLES -> IDLE, no memory access, no response.
REQ-033 Without DEBUG_MEM_TIMEOUT_EN: no counter; GET_ADDR/GET_DATA wait indefinitely.

Verification
REQ-034 Send 0x1F,00,00,00,10,DE,AD,BE,EF -> one cycle mem_addr=0x4, mem_we=4'hF, mem_wdata=0xDEADBEEF; tx 0xAA.
REQ-035 Preload mem_rdata=0x12345678 at word 0x4; send 0x20,00,00,00,12 -> mem_addr=0x4; tx 0x12,0x34,0x56,0x78 in order; tx_valid at edge N+2.
REQ-036 Send 0x13,...,addr 0x8,data 0xAABBCCDD -> mem_we=4'b0011 one cycle; tx 0xAA; then 0x10 write -> mem_we stays 0, tx 0xAA.
REQ-037 Send 0x55 -> tx 0xEE, no mem_we; hold tx_ready=0 for 5 cycles -> tx_data stays 0xEE, rx_ready stays 0.
REQ-038 Assert rst after 2 address bytes -> all outputs at reset values; following full read frame completes correctly.
REQ-039 With DEBUG_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16: stall 16 cycles after command byte -> busy falls, no tx, no mem_we.
